// File: rtl/biset_reg_target_pkg.sv
// BiSet bus types shared by the driver and the register target:
// request control, write operand and reply.
package BiSet;

  localparam int BISET_CTRLLEN  = 11;
  localparam int BISET_DATALEN  = 32;
  localparam int BISET_REPLYLEN = 34;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_SET   = 3'd3,
    OP_CLEAR = 3'd4
  } biSetOp;

  typedef logic [BISET_DATALEN-1:0] biSetData;

  // The op field can carry the illegal codes 5..7, so it must not be treated as closed.
  typedef struct packed {
    biSetOp     op;
    logic [7:0] addr;
  } biSetCtrl;

  typedef struct packed {
    logic                     ack;
    logic                     err;
    logic [BISET_DATALEN-1:0] rdata;
  } biSetReply;

endpackage

// File: rtl/biset_reg_target_cell.sv
// One control/status register: applies a bus WRITE/SET/CLEAR limited to the
// writable bits, then ORs in sticky hardware set bits.
module biset_reg_cell
  import BiSet::*;
#(
  parameter logic [31:0] RESET_VAL = '0,
  parameter logic [31:0] WMASK     = '1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel,
  input  biSetOp      op,
  input  logic [31:0] wdata,
  input  logic [31:0] hwset,
  output logic [31:0] value,
  output logic        wstrobe
);

  logic [31:0] value_reg;
  logic [31:0] bus_next;
  logic [31:0] wbits;
  logic        wstrobe_reg;

  assign wbits = wdata & WMASK;

  always_comb begin
    bus_next = value_reg;
    if (sel) begin
      case (op)
        OP_WRITE: bus_next = (value_reg & ~WMASK) | wbits;
        OP_SET:   bus_next = value_reg | wbits;
        OP_CLEAR: bus_next = value_reg & ~wbits;
        default:  bus_next = value_reg;
      endcase
    end
  end

  // Hardware set is applied after the bus op so a same-cycle CLEAR never loses an event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_reg   <= RESET_VAL;
      wstrobe_reg <= 1'b0;
    end else begin
      value_reg   <= bus_next | hwset;
      wstrobe_reg <= sel;
    end
  end

  assign value   = value_reg;
  assign wstrobe = wstrobe_reg;

endmodule

// File: rtl/biset_reg_target.sv
// BiSet bus target: decodes requests onto a bank of register cells and
// returns a registered reply one cycle after each request.
module biset_reg_target
  import BiSet::*;
#(
  parameter int                     NREGS     = 8,
  parameter logic [NREGS-1:0][31:0] RESET_VAL = '0,
  parameter logic [NREGS-1:0][31:0] WMASK     = '1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  biSetCtrl                 ctrl_i,
  input  biSetData                 write_i,
  output biSetReply                reply_o,
  output logic [NREGS-1:0][31:0]   regs_o,
  output logic [NREGS-1:0]         wstrobe_o,
  input  logic [NREGS-1:0][31:0]   hwset_i
);

  biSetOp     op;
  logic [7:0] addr;
  logic       addr_ok;
  logic       is_req;
  logic       is_read;
  logic       is_mod;
  logic       is_err;
  logic [31:0] rdata_mux;
  logic [NREGS-1:0] sel;
  biSetReply  reply_reg;

  assign op      = ctrl_i.op;
  assign addr    = ctrl_i.addr;
  assign addr_ok = ({1'b0, addr} < 9'(NREGS));
  assign is_req  = (op != OP_NOP);
  assign is_read = (op == OP_READ) && addr_ok;
  assign is_mod  = ((op == OP_WRITE) || (op == OP_SET) || (op == OP_CLEAR)) && addr_ok;
  assign is_err  = is_req && !is_read && !is_mod;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      assign sel[gi] = is_mod && (addr == 8'(gi));

      biset_reg_cell #(
        .RESET_VAL(RESET_VAL[gi]),
        .WMASK    (WMASK[gi])
      ) u_cell (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sel    (sel[gi]),
        .op     (op),
        .wdata  (write_i),
        .hwset  (hwset_i[gi]),
        .value  (regs_o[gi]),
        .wstrobe(wstrobe_o[gi])
      );
    end
  endgenerate

  // Reads see the registered value, so same-cycle hardware sets are excluded.
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == 8'(i)) rdata_mux = regs_o[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !is_req) begin
      reply_reg <= '0;
    end else if (is_err) begin
      reply_reg <= '{ack: 1'b1, err: 1'b1, rdata: 32'h0};
    end else if (is_read) begin
      reply_reg <= '{ack: 1'b1, err: 1'b0, rdata: rdata_mux};
    end else begin
      reply_reg <= '{ack: 1'b1, err: 1'b0, rdata: 32'h0};
    end
  end

  assign reply_o = reply_reg;

endmodule

// File: tb/tb_biset_reg_target.sv
// Scoreboard bench for biset_reg_target: a bit-level register model predicts
// the reply, strobes and register bank for every cycle.
module tb_biset_reg_target;
  import BiSet::*;

  localparam int NREGS = 8;
  localparam logic [NREGS-1:0][31:0] RST_V = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0000, 32'h0, 32'h0};
  localparam logic [NREGS-1:0][31:0] WMASK_V = {
    32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  biSetCtrl               ctrl_i;
  biSetData               write_i;
  biSetReply              reply_o;
  logic [NREGS-1:0][31:0] regs_o;
  logic [NREGS-1:0]       wstrobe_o;
  logic [NREGS-1:0][31:0] hwset_i;

  biset_reg_target #(
    .NREGS    (NREGS),
    .RESET_VAL(RST_V),
    .WMASK    (WMASK_V)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ctrl_i   (ctrl_i),
    .write_i  (write_i),
    .reply_o  (reply_o),
    .regs_o   (regs_o),
    .wstrobe_o(wstrobe_o),
    .hwset_i  (hwset_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [NREGS-1:0][31:0] model = RST_V;
  logic [33:0]      rep_q[$];
  logic [NREGS-1:0] strb_q[$];

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, predict, clock, then compare against the scoreboard.
  task automatic cyc(input logic rst, input logic [2:0] op, input logic [7:0] addr,
                     input logic [31:0] data, input int hw_idx, input logic [31:0] hw_val);
    logic [33:0]      rep;
    logic [NREGS-1:0] strb;
    logic [31:0]      m;
    logic [33:0]      got_rep;
    logic [NREGS-1:0] got_strb;
    int               a;
    a = int'(addr);
    rst_i   = rst;
    ctrl_i  = '{op: biSetOp'(op), addr: addr};
    write_i = data;
    hwset_i = '0;
    if (hw_idx >= 0) hwset_i[hw_idx] = hw_val;
    rep  = '0;
    strb = '0;
    if (rst) begin
      model = RST_V;
    end else begin
      if (op != 3'd0) begin
        if (op > 3'd4 || a >= NREGS) begin
          rep = {2'b11, 32'h0};
        end else if (op == 3'd1) begin
          rep = {2'b10, model[a]};
        end else begin
          m = data & WMASK_V[a];
          case (op)
            3'd2:    model[a] = (model[a] & ~WMASK_V[a]) | m;
            3'd3:    model[a] = model[a] | m;
            default: model[a] = model[a] & ~m;
          endcase
          strb[a] = 1'b1;
          rep = {2'b10, 32'h0};
        end
      end
      for (int i = 0; i < NREGS; i++) model[i] = model[i] | hwset_i[i];
    end
    rep_q.push_back(rep);
    strb_q.push_back(strb);
    @(posedge clk_i);
    #1;
    $display("txn rst=%0b op=%0d addr=%0d data=%08h -> reply=%09h strobe=%02h",
             rst, op, addr, data, reply_o, wstrobe_o);
    if (rep_q.size() == 0) begin
      check_val("scoreboard_empty", 256'd1, 256'd0);
    end else begin
      got_rep  = reply_o;
      got_strb = wstrobe_o;
      check_val("reply", 256'(got_rep), 256'(rep_q.pop_front()));
      check_val("wstrobe", 256'(got_strb), 256'(strb_q.pop_front()));
      check_val("regs", 256'(regs_o), 256'(model));
    end
  endtask

  initial begin
    logic [33:0] r;
    rst_i = 1'b1; ctrl_i = '0; write_i = '0; hwset_i = '0;
    cyc(1, 0, 0, 0, -1, 0);
    cyc(1, 0, 0, 0, 3, 32'hFFFF_FFFF);       // hwset ignored while in reset
    check_val("reset_reg2", 256'(regs_o[2]), 256'(32'hA5A5_0000));
    check_val("reset_reg3", 256'(regs_o[3]), 256'(32'h0));

    cyc(0, 1, 2, 0, -1, 0);
    r = reply_o;
    check_val("read_reset_val", 256'(r), 256'({2'b10, 32'hA5A5_0000}));

    cyc(0, 2, 1, 32'hFFFF_FFFF, -1, 0);
    check_val("masked_write", 256'(regs_o[1]), 256'(32'h0000_00FF));
    cyc(0, 1, 1, 0, -1, 0);
    r = reply_o;
    check_val("b2b_read", 256'(r), 256'({2'b10, 32'h0000_00FF}));
    cyc(0, 0, 0, 0, -1, 0);

    cyc(0, 3, 0, 32'h11, -1, 0);
    check_val("set_val", 256'(regs_o[0]), 256'(32'h11));
    cyc(0, 4, 0, 32'h01, -1, 0);
    check_val("clear_val", 256'(regs_o[0]), 256'(32'h10));

    cyc(0, 2, 3, 32'h1, -1, 0);
    cyc(0, 4, 3, 32'h1, 3, 32'h1);            // CLEAR racing hwset keeps the bit
    check_val("clear_vs_hwset", 256'(regs_o[3]), 256'(32'h1));
    cyc(0, 1, 4, 0, 4, 32'h80);               // READ excludes same-cycle hwset
    r = reply_o;
    check_val("read_pre_hwset", 256'(r), 256'({2'b10, 32'h0}));
    cyc(0, 2, 6, 32'h0, 6, 32'h4);            // WRITE 0 racing hwset keeps the bit

    cyc(0, 1, 8'(NREGS), 0, -1, 0);
    cyc(0, 6, 0, 32'hFFFF_FFFF, -1, 0);
    r = reply_o;
    check_val("illegal_op", 256'(r), 256'({2'b11, 32'h0}));
    cyc(0, 0, 0, 0, -1, 0);
    cyc(0, 0, 0, 0, -1, 0);

    cyc(0, 2, 5, 32'hDEAD_BEEF, -1, 0);
    cyc(1, 2, 5, 32'h1234, -1, 0);            // request in reset cycle is dropped
    cyc(0, 0, 0, 0, -1, 0);
    check_val("rst_write_dropped", 256'(regs_o[5]), 256'(32'h0));

    for (int k = 0; k < 60; k++) begin
      cyc(0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 9)), $urandom,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1)) : -1,
          $urandom & $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
